// File: rtl/field_pkg.sv
// Shared constants, Q16.16 types and FSM encoding for the field normaliser.
package field_pkg;

  localparam int FIELD_WIDTH_DEF  = 8;
  localparam int FIELD_HEIGHT_DEF = 6;
  localparam int FIELD_SIZE_DEF   = FIELD_WIDTH_DEF * FIELD_HEIGHT_DEF;
  localparam int FIELD_ADDRW_DEF  = $clog2(FIELD_SIZE_DEF);
  localparam int VEL_DATAW_DEF    = 64;
  localparam int FIELD_DATAW_DEF  = 96;

  localparam int SQRT_ITERS  = 32;
  localparam int DIV_CYCLES  = 48;
  localparam int CELL_CYCLES = 3 + SQRT_ITERS + 2 * DIV_CYCLES + 1;

  localparam logic [31:0] FX_ONE = 32'h0001_0000;

  typedef logic signed [31:0] fx_t;

  typedef struct packed {
    fx_t xn;
    fx_t yn;
    fx_t mag;
  } field_word_t;

  typedef struct packed {
    fx_t vx;
    fx_t vy;
  } vel_word_t;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_READ   = 4'd1,
    S_WAIT   = 4'd2,
    S_SQUARE = 4'd3,
    S_SQRT   = 4'd4,
    S_DIV_X  = 4'd5,
    S_DIV_Y  = 4'd6,
    S_WRITE  = 4'd7,
    S_DONE   = 4'd8
  } state_e;

  function automatic logic [31:0] fx_abs(input fx_t v);
    logic [31:0] u;
    u = v;
    if (v[31]) begin
      fx_abs = ~u + 32'd1;
    end else begin
      fx_abs = u;
    end
  endfunction

  // Clip an unsigned quotient to 1.0, then restore the sign; a zero magnitude forces 0.
  function automatic fx_t fx_unit(input logic [47:0] quot, input logic neg, input logic zero);
    logic [31:0] clip;
    if (zero) begin
      clip = 32'd0;
    end else if (quot > {16'd0, FX_ONE}) begin
      clip = FX_ONE;
    end else begin
      clip = quot[31:0];
    end
    if (neg) begin
      fx_unit = ~clip + 32'd1;
    end else begin
      fx_unit = clip;
    end
  endfunction

endpackage

// File: rtl/fx_divider.sv
// Unsigned restoring divider: 48-bit dividend by 32-bit divisor, one quotient bit per cycle.
module fx_divider
  import field_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [47:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [47:0] quotient_o
);

  logic [31:0] rem_q;
  logic [31:0] rem_d;
  logic [31:0] dvs_q;
  logic [31:0] dvs_s;
  logic [47:0] acc_q;
  logic [47:0] acc_d;
  logic [46:0] acc_low_s;
  logic        msb_s;
  logic [32:0] rem_shift_s;
  logic [5:0]  cnt_q;
  logic        active_q;
  logic        done_q;

  // One restoring step; a start performs the first step directly on the fresh operands.
  always_comb begin
    if (start_i) begin
      msb_s       = dividend_i[47];
      acc_low_s   = dividend_i[46:0];
      dvs_s       = divisor_i;
      rem_shift_s = {32'd0, msb_s};
    end else begin
      msb_s       = acc_q[47];
      acc_low_s   = acc_q[46:0];
      dvs_s       = dvs_q;
      rem_shift_s = {rem_q, msb_s};
    end
    if (rem_shift_s >= {1'b0, dvs_s}) begin
      rem_d = 32'(rem_shift_s - {1'b0, dvs_s});
      acc_d = {acc_low_s, 1'b1};
    end else begin
      rem_d = rem_shift_s[31:0];
      acc_d = {acc_low_s, 1'b0};
    end
  end

  // Load on start, then step until all quotient bits have shifted into the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
      acc_q    <= 48'd0;
      cnt_q    <= 6'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q    <= rem_d;
        acc_q    <= acc_d;
        dvs_q    <= divisor_i;
        cnt_q    <= 6'd1;
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q <= rem_d;
        acc_q <= acc_d;
        if (cnt_q == 6'(DIV_CYCLES - 1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
          cnt_q    <= 6'd0;
        end else begin
          cnt_q <= cnt_q + 6'd1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = acc_q;

endmodule

// File: rtl/field_normalize.sv
// Sweeps the velocity field and writes {xn, yn, mag} for every cell at a fixed cost per cell,
// so the consumer can sequence on done alone.
module field_normalize
  import field_pkg::*;
#(
  parameter int FIELD_WIDTH  = FIELD_WIDTH_DEF,
  parameter int FIELD_HEIGHT = FIELD_HEIGHT_DEF,
  parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
  parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
  parameter int VEL_DATAW    = VEL_DATAW_DEF,
  parameter int FIELD_DATAW  = FIELD_DATAW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [FIELD_ADDRW-1:0] vel_addr_read,
  input  logic [VEL_DATAW-1:0]   vel_data_out,
  output logic                   field_we,
  output logic [FIELD_ADDRW-1:0] field_addr_write,
  output logic [FIELD_DATAW-1:0] field_data_in
);

  localparam logic [FIELD_ADDRW-1:0] LAST_CELL = FIELD_ADDRW'(FIELD_SIZE - 1);

  state_e                 state_q;
  logic [FIELD_ADDRW-1:0] cell_q;
  logic [5:0]             cnt_q;
  logic [31:0]            abs_x_q;
  logic [31:0]            abs_y_q;
  logic                   neg_x_q;
  logic                   neg_y_q;
  logic [63:0]            rad_q;
  logic [63:0]            rad_d;
  logic [32:0]            rem_q;
  logic [32:0]            rem_d;
  logic [31:0]            root_q;
  logic [31:0]            root_d;
  logic [31:0]            mag_q;
  fx_t                    xn_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   we_q;
  logic [FIELD_ADDRW-1:0] vel_addr_q;
  logic [FIELD_ADDRW-1:0] wr_addr_q;
  field_word_t            wr_data_q;

  vel_word_t              vel_s;
  logic [31:0]            abs_x_s;
  logic [31:0]            abs_y_s;
  logic [63:0]            sum_s;
  logic [34:0]            rem_shift_s;
  logic [34:0]            trial_s;
  logic                   div_start_s;
  logic [47:0]            div_dvd_s;
  logic                   div_done_s;
  logic [47:0]            div_quot_s;
  logic                   mag_zero_s;

  // Squaring, one restoring square-root step, and divider operand selection.
  always_comb begin
    vel_s       = vel_data_out;
    abs_x_s     = fx_abs(vel_s.vx);
    abs_y_s     = fx_abs(vel_s.vy);
    sum_s       = {32'd0, abs_x_s} * {32'd0, abs_x_s} + {32'd0, abs_y_s} * {32'd0, abs_y_s};
    rem_shift_s = {rem_q, rad_q[63:62]};
    trial_s     = {1'b0, root_q, 2'b01};
    rad_d       = {rad_q[61:0], 2'b00};
    if (rem_shift_s >= trial_s) begin
      rem_d  = 33'(rem_shift_s - trial_s);
      root_d = {root_q[30:0], 1'b1};
    end else begin
      rem_d  = rem_shift_s[32:0];
      root_d = {root_q[30:0], 1'b0};
    end
    div_start_s = ((state_q == S_DIV_X) || (state_q == S_DIV_Y)) && (cnt_q == 6'd0);
    if (state_q == S_DIV_Y) begin
      div_dvd_s = {abs_y_q, 16'd0};
    end else begin
      div_dvd_s = {abs_x_q, 16'd0};
    end
    mag_zero_s = (mag_q == 32'd0);
  end

  // Shared divider: X is captured as Y starts, Y is consumed in WRITE.
  fx_divider u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start_s),
    .dividend_i (div_dvd_s),
    .divisor_i  (mag_q),
    .done_o     (div_done_s),
    .quotient_o (div_quot_s)
  );

  // Sweep sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cell_q     <= {FIELD_ADDRW{1'b0}};
      cnt_q      <= 6'd0;
      abs_x_q    <= 32'd0;
      abs_y_q    <= 32'd0;
      neg_x_q    <= 1'b0;
      neg_y_q    <= 1'b0;
      rad_q      <= 64'd0;
      rem_q      <= 33'd0;
      root_q     <= 32'd0;
      mag_q      <= 32'd0;
      xn_q       <= 32'sd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      vel_addr_q <= {FIELD_ADDRW{1'b0}};
      wr_addr_q  <= {FIELD_ADDRW{1'b0}};
      wr_data_q  <= 96'd0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cell_q     <= {FIELD_ADDRW{1'b0}};
            vel_addr_q <= {FIELD_ADDRW{1'b0}};
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: state_q <= S_WAIT;
        S_WAIT: state_q <= S_SQUARE;
        S_SQUARE: begin
          abs_x_q <= abs_x_s;
          abs_y_q <= abs_y_s;
          neg_x_q <= vel_s.vx[31];
          neg_y_q <= vel_s.vy[31];
          rad_q   <= sum_s;
          rem_q   <= 33'd0;
          root_q  <= 32'd0;
          cnt_q   <= 6'd0;
          state_q <= S_SQRT;
        end
        S_SQRT: begin
          rad_q  <= rad_d;
          rem_q  <= rem_d;
          root_q <= root_d;
          if (cnt_q == 6'(SQRT_ITERS - 1)) begin
            mag_q   <= root_d;
            cnt_q   <= 6'd0;
            state_q <= S_DIV_X;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DIV_X: begin
          if (cnt_q == 6'(DIV_CYCLES - 1)) begin
            cnt_q   <= 6'd0;
            state_q <= S_DIV_Y;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DIV_Y: begin
          if (div_done_s) begin
            xn_q <= fx_unit(div_quot_s, neg_x_q, mag_zero_s);
          end
          if (cnt_q == 6'(DIV_CYCLES - 1)) begin
            cnt_q   <= 6'd0;
            state_q <= S_WRITE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_WRITE: begin
          we_q      <= 1'b1;
          wr_addr_q <= cell_q;
          wr_data_q <= {xn_q, fx_unit(div_quot_s, neg_y_q, mag_zero_s), mag_q};
          if (cell_q == LAST_CELL) begin
            state_q <= S_DONE;
          end else begin
            cell_q     <= cell_q + FIELD_ADDRW'(1);
            vel_addr_q <= cell_q + FIELD_ADDRW'(1);
            state_q    <= S_READ;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign field_we         = we_q;
  assign vel_addr_read    = vel_addr_q;
  assign field_addr_write = wr_addr_q;
  assign field_data_in    = wr_data_q;

endmodule

// File: tb/tb_field_normalize.sv
// Directed bench for field_normalize: known vectors, sweep timing, ignored start, mid-sweep reset.
module tb_field_normalize;
  import field_pkg::*;

  localparam int N     = FIELD_SIZE_DEF;
  localparam int AW    = FIELD_ADDRW_DEF;
  localparam int NVEC  = 6;
  localparam int LAST  = CELL_CYCLES * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] vel_addr_read;
  logic [63:0]   vel_data_out;
  logic          field_we;
  logic [AW-1:0] field_addr_write;
  logic [95:0]   field_data_in;

  logic [63:0]   vel_mem  [N];
  logic [63:0]   vec_vel  [NVEC];
  logic [95:0]   vec_word [NVEC];

  int vectors     = 0;
  int miscompares = 0;
  int writes;

  field_normalize dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .vel_addr_read    (vel_addr_read),
    .vel_data_out     (vel_data_out),
    .field_we         (field_we),
    .field_addr_write (field_addr_write),
    .field_data_in    (field_data_in)
  );

  always #5 clk = ~clk;

  // Velocity BRAM: one cycle read latency.
  always @(posedge clk) vel_data_out <= vel_mem[vel_addr_read];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_we"},    field_we, 1'b0);
    check({tag, "_raddr"}, vel_addr_read, 0);
    check({tag, "_waddr"}, field_addr_write, 0);
    check({tag, "_wdata"}, field_data_in, 96'h0);
  endtask

  initial begin
    vec_vel[0] = 64'h00030000_00040000; vec_word[0] = 96'h00009999_0000CCCC_00050000;
    vec_vel[1] = 64'hFFFD0000_00040000; vec_word[1] = 96'hFFFF6667_0000CCCC_00050000;
    vec_vel[2] = 64'h00000000_00000000; vec_word[2] = 96'h00000000_00000000_00000000;
    vec_vel[3] = 64'h00010000_00000000; vec_word[3] = 96'h00010000_00000000_00010000;
    vec_vel[4] = 64'h00050000_000C0000; vec_word[4] = 96'h00006276_0000EC4E_000D0000;
    vec_vel[5] = 64'h00010000_FFFF0000; vec_word[5] = 96'h0000B505_FFFF4AFB_00016A09;
    for (int k = 0; k < N; k++) vel_mem[k] = vec_vel[k % NVEC];

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Full sweep; a start pulse mid-sweep must be ignored.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    writes = 0;
    for (int rel = 0; rel <= LAST + 4; rel++) begin
      if (rel > 0) @(negedge clk);
      if (rel == 500) start = 1'b1;
      if (rel == 501) start = 1'b0;
      check("sweep_we",   field_we, (rel > 0) && (rel % CELL_CYCLES == 0) && (rel <= LAST));
      check("sweep_done", done, rel == LAST + 1);
      check("sweep_busy", busy, rel <= LAST);
      if ((rel > 0) && (rel % CELL_CYCLES == 0) && (rel <= LAST)) begin
        check("sweep_waddr", field_addr_write, rel / CELL_CYCLES - 1);
        check("sweep_wdata", field_data_in, vec_word[(rel / CELL_CYCLES - 1) % NVEC]);
      end
      if ((rel % CELL_CYCLES == 0) && (rel < LAST))
        check("sweep_raddr", vel_addr_read, rel / CELL_CYCLES);
      if (field_we) writes++;
    end
    check("sweep_nwrites", writes, N);

    // Reset during cell 10.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    writes = 0;
    for (int rel = 1; rel <= 1400; rel++) begin
      @(negedge clk);
      if (field_we) begin
        check("pre_rst_waddr", field_addr_write, writes);
        writes++;
      end
    end
    check("pre_rst_nwrites", writes, 10);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    writes = 0;
    for (int rel = 0; rel < 140; rel++) begin
      @(negedge clk);
      if (field_we || busy) writes++;
    end
    check("post_rst_idle", writes, 0);

    // Restart must begin at cell 0.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    writes = 0;
    for (int rel = 1; rel <= CELL_CYCLES; rel++) begin
      @(negedge clk);
      if (field_we) writes++;
      if (rel == CELL_CYCLES) begin
        check("restart_we",    field_we, 1'b1);
        check("restart_waddr", field_addr_write, 0);
        check("restart_wdata", field_data_in, vec_word[0]);
      end
    end
    check("restart_nwrites", writes, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/field_normalize.md
# field_normalize

Upstream producer of the vector-field memory consumed by the block-drawing stage. On `start` it sweeps every field cell and reads the raw velocity `{vx, vy}` from the velocity BRAM. It computes `mag = sqrt(vx² + vy²)` and the unit components `xn = vx/mag` and `yn = vy/mag`, then writes the packed `{xn, yn, mag}` word into the field BRAM. All values are signed Q16.16. Every cell takes the same fixed number of cycles, so the drawing stage can be sequenced against `done` alone.

## Interface
Parameters:
- `FIELD_WIDTH`, 8, cells per row
- `FIELD_HEIGHT`, 6, cells per column
- `FIELD_SIZE`, `FIELD_WIDTH*FIELD_HEIGHT`, number of cells
- `FIELD_ADDRW`, `$clog2(FIELD_SIZE)`, cell address width
- `VEL_DATAW`, 64, velocity word `{vx[63:32], vy[31:0]}`
- `FIELD_DATAW`, 96, field word `{xn[95:64], yn[63:32], mag[31:0]}`

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the last cell is written.
- `vel_addr_read` out `FIELD_ADDRW`: velocity BRAM read address.
- `vel_data_out` in `VEL_DATAW`: velocity BRAM read data, valid 1 cycle after the address.
- `field_we` out 1: field BRAM write enable.
- `field_addr_write` out `FIELD_ADDRW`: field BRAM write address.
- `field_data_in` out `FIELD_DATAW`: field BRAM write data.

## Operation
- States: IDLE → READ → WAIT → SQUARE → SQRT → DIV_X → DIV_Y → WRITE → (READ for the next cell | DONE) → IDLE.
- IDLE: `start`=1 clears the cell counter and enters READ. `start` outside IDLE is ignored.
- READ: drive `vel_addr_read` = cell.
- WAIT: one cycle for the BRAM read latency.
- SQUARE: latch `vx`/`vy` from `vel_data_out`; `sum = vx*vx + vy*vy`, unsigned 64-bit Q32.32. This sum cannot overflow.
- SQRT: bit-serial restoring integer square root of `sum`, 32 iterations at 1 bit/cycle. Result is `mag`, Q16.16, truncated and non-negative.
- DIV_X: `|vx|<<16 / mag` via `fx_divider`, 48 cycles. Quotient is truncated toward zero and clipped to 0x0001_0000. Negate if `vx<0`.
- DIV_Y: same computation on `vy`.
- `mag==0`: `xn=yn=0`. The divider still runs its full cycle count with its result discarded, so latency is unchanged.
- WRITE: `field_we`=1 for one cycle, `field_addr_write`=cell, `field_data_in={xn,yn,mag}`. If cell==`FIELD_SIZE-1` go to DONE; otherwise cell+1 → READ.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- Reset values: `busy`, `done`, `field_we` = 0; all addresses and data outputs = 0; state = IDLE.
- Reset mid-sweep: abort immediately with no partial write. The next `start` restarts at cell 0.

## Timing
- `CELL_CYCLES` = 132 (READ 1, WAIT 1, SQUARE 1, SQRT 32, DIV_X 48, DIV_Y 48, WRITE 1).
- `start` sampled high at edge T0: cell k is written (`field_we` high) in cycle T0+132·(k+1). `done` is high in cycle T0+132·`FIELD_SIZE`+1.
- Default parameters: 48 writes, `done` at T0+6337.
- A new `start` is accepted no earlier than the cycle after `done`.
- Field addresses are strictly increasing 0..`FIELD_SIZE-1`. No wrap within a sweep.

## Structure
- Package `field_pkg`:
  - `FIELD_*` constants
  - `typedef logic signed [31:0] fx_t` (Q16.16)
  - packed struct `field_word_t {xn, yn, mag}` and velocity struct `{vx, vy}`
  - `CELL_CYCLES`
  - FSM state enum
- Sub-module `fx_divider`:
  - unsigned restoring divider: 48-bit dividend, 32-bit divisor, 48 cycles
  - `start`/`done` handshake
  - reused for X then Y
- The square root stays inline in the FSM.

## Test plan
- vx=3.0 (0x00030000), vy=4.0 (0x00040000) → `mag`=0x00050000, `xn`=0x00009999, `yn`=0x0000CCCC.
- vx=−3.0, vy=4.0 → `mag`=0x00050000, `xn`=0xFFFF6667, `yn`=0x0000CCCC.
- vx=vy=0 → word = 96'h0; the write still lands exactly 132 cycles after the previous write.
- vx=1.0, vy=0 → `mag`=0x00010000, `xn`=0x00010000, `yn`=0.
- Full sweep with `start` at T0 → 48 writes at addresses 0..47, spaced 132 cycles apart; `done` pulses once at T0+6337. A `start` pulse at T0+500 is ignored.
- `rst_n` low during cell 10 → outputs return to zero asynchronously; no write to cell 10. The next `start` writes cell 0 first.
